// File: rtl/cpu_types_pkg.sv
// Shared CPU-side memory types: RAM port status, arbiter FSM state and grant owner.
// Pure type definitions; no timing or flow-control behaviour of its own.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    IGNT = 2'b01,
    DGNT = 2'b10,
    ERR  = 2'b11
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;
endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog counter for one granted RAM access; expire is combinational at count TIMEOUT-1.
// Counts only while enabled, clear has priority; no backpressure.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 256
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)   count_d = '0;
    else if (en) count_d = count_q + CW'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expire = en && (count_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Round-robin icache/dcache arbiter onto one RAM port; RAM driven 1 cycle after request.
// Requester stalls (wait high) until ACCESS, RAM ERROR or watchdog expiry completes the grant.
module mem_arbiter_ctrl
  import cpu_types_pkg::*;
#(
  parameter int    TIMEOUT  = 256,
  parameter word_t ERR_WORD = 32'hBAD1BAD1
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      memREN,
  output logic      memWEN,
  output word_t     memaddr,
  output word_t     memstore,
  input  ramstate_t ramstate,
  input  word_t     ramload,
  output logic      bus_error
);
  arb_state_t state_q, state_d;
  gnt_t       last_gnt_q, last_gnt_d;
  logic       memren_q, memren_d, memwen_q, memwen_d;
  word_t      memaddr_q, memaddr_d, memstore_q, memstore_d;
  logic       bus_error_q, bus_error_d;

  logic i_pend, d_pend, granted, expire, ram_done, err_hit;
  logic i_act, d_act;

  assign i_pend   = iREN;
  assign d_pend   = dREN || dWEN;
  assign granted  = (state_q == IGNT) || (state_q == DGNT);
  assign ram_done = (ramstate == ACCESS);
  assign err_hit  = !ram_done && ((ramstate == ERROR) || expire);
  // A grant whose requester has gone away is an abort, never a completion.
  assign i_act    = (state_q == IGNT) && i_pend;
  assign d_act    = (state_q == DGNT) && d_pend;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .CLK    (CLK),
    .nRST   (nRST),
    .clear  (!granted),
    .en     (granted),
    .expire (expire)
  );

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    memren_d    = memren_q;
    memwen_d    = memwen_q;
    memaddr_d   = memaddr_q;
    memstore_d  = memstore_q;
    bus_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        memren_d = 1'b0;
        memwen_d = 1'b0;
        if (d_pend && (!i_pend || last_gnt_q == GNT_I)) begin
          state_d    = DGNT;
          memaddr_d  = daddr;
          memstore_d = dstore;
          memwen_d   = dWEN;
          memren_d   = dREN && !dWEN;
        end else if (i_pend) begin
          state_d    = IGNT;
          memaddr_d  = iaddr;
          memstore_d = '0;
          memren_d   = 1'b1;
        end
      end
      IGNT, DGNT: begin
        if (!(i_act || d_act)) begin
          state_d  = IDLE;
          memren_d = 1'b0;
          memwen_d = 1'b0;
        end else if (ram_done || err_hit) begin
          state_d     = ram_done ? IDLE : ERR;
          bus_error_d = err_hit;
          last_gnt_d  = (state_q == IGNT) ? GNT_I : GNT_D;
          memren_d    = 1'b0;
          memwen_d    = 1'b0;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      last_gnt_q  <= GNT_I;
      memren_q    <= 1'b0;
      memwen_q    <= 1'b0;
      memaddr_q   <= '0;
      memstore_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      memren_q    <= memren_d;
      memwen_q    <= memwen_d;
      memaddr_q   <= memaddr_d;
      memstore_q  <= memstore_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    iwait = i_pend;
    dwait = d_pend;
    iload = '0;
    dload = '0;
    if (i_act && (ram_done || err_hit)) begin
      iwait = 1'b0;
      iload = ram_done ? ramload : ERR_WORD;
    end
    if (d_act && (ram_done || err_hit)) begin
      dwait = 1'b0;
      dload = ram_done ? ramload : ERR_WORD;
    end
  end

  assign memREN    = memren_q;
  assign memWEN    = memwen_q;
  assign memaddr   = memaddr_q;
  assign memstore  = memstore_q;
  assign bus_error = bus_error_q;

  a_no_rd_wr: assert property (@(posedge CLK) disable iff (!nRST) !(dREN && dWEN))
    else $error("dREN and dWEN asserted together");
endmodule
